design67_15_45_core: RTL and testbench

- Registered 8-bit datapath benchmark block: samples the low byte of a 32-bit input bus and produces a 32-bit registered status/result word.
- Result word packs sum, nibble product, LFSR scramble, population count and flag results.
- Used as the golden behavioural top for place-and-route equivalence checking; in[31:8] are don't-care.

---
 rtl/design67_15_45_core.sv | 71 +++++++
 tb/tb_design67_15_45_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/design67_15_45_core.sv
// Registered 8-bit datapath block: input stage, accumulator and LFSR feeding a packed 32-bit result word.
// Optional build macro D67_OUT_PARITY_EN replaces out[31] (carry) with even parity over the whole word.
module design67_15_45_core #(
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    logic [7:0]  r_inQ;
    logic [7:0]  r_acc;
    logic [7:0]  r_lfsr;
    logic [31:0] r_out;

    logic [8:0]  w_sum;
    logic [7:0]  w_prod;
    logic [3:0]  w_ones;
    logic [7:0]  w_lfsrNext;
    logic [31:0] w_outNext;
    logic [23:0] w_unusedHigh;

    // The upper input bits are don't-care for this block.
    assign w_unusedHigh = in[31:8];

    assign w_sum      = {1'b0, r_inQ} + {1'b0, r_acc};
    assign w_prod     = {4'b0000, r_inQ[3:0]} * {4'b0000, r_inQ[7:4]};
    assign w_lfsrNext = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'b000, r_inQ[i]};
        end
    end

    always_comb begin
        w_outNext        = 32'd0;
        w_outNext[7:0]   = w_sum[7:0];
        w_outNext[15:8]  = w_prod;
        w_outNext[23:16] = r_lfsr ^ r_inQ;
        w_outNext[27:24] = w_ones;
        w_outNext[28]    = ^r_inQ;
        w_outNext[29]    = (r_inQ == 8'd0);
        w_outNext[30]    = (r_inQ > r_acc);
`ifdef D67_OUT_PARITY_EN
        w_outNext[31]    = ^w_outNext[30:0];
`else
        w_outNext[31]    = w_sum[8];
`endif
    end

    // All state advances every cycle; reset clears immediately regardless of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inQ  <= 8'd0;
            r_acc  <= 8'd0;
            r_lfsr <= LFSR_SEED;
            r_out  <= 32'd0;
        end else begin
            r_inQ  <= in[7:0];
            r_acc  <= r_acc + r_inQ;
            r_lfsr <= w_lfsrNext;
            r_out  <= w_outNext;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_design67_15_45_core.sv
// Self-checking bench for design67_15_45_core: behavioural model feeds a scoreboard queue,
// plus directed checks of reset, LFSR sequence, byte-0x35 fields and accumulator wrap.
module tb_design67_15_45_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in;
    logic [31:0] out;

    design67_15_45_core dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    logic [31:0] expQ[$];
    logic [7:0]  mInQ;
    logic [7:0]  mAcc;
    logic [7:0]  mLfsr;
    logic [31:0] mOut;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mInQ  = 8'd0;
        mAcc  = 8'd0;
        mLfsr = 8'h01;
        mOut  = 32'd0;
        expQ.delete();
    endtask

    // Advance the reference model by one rising edge with input v.
    task automatic modelEdge(input logic [31:0] v);
        logic [8:0]  s;
        logic [31:0] o;
        int          p;
        s        = {1'b0, mInQ} + {1'b0, mAcc};
        p        = int'(mInQ[3:0]) * int'(mInQ[7:4]);
        o        = 32'd0;
        o[7:0]   = s[7:0];
        o[15:8]  = p[7:0];
        o[23:16] = mLfsr ^ mInQ;
        o[27:24] = 4'($countones(mInQ));
        o[28]    = ^mInQ;
        o[29]    = (mInQ == 8'd0);
        o[30]    = (mInQ > mAcc);
`ifdef D67_OUT_PARITY_EN
        o[31]    = ^o[30:0];
`else
        o[31]    = s[8];
`endif
        mAcc  = mAcc + mInQ;
        mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
        mInQ  = v[7:0];
        mOut  = o;
    endtask

    task automatic applyStimulus(input logic [31:0] v, input string tag);
        logic [31:0] e;
        in = v;
        modelEdge(v);
        expQ.push_back(mOut);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput(tag, out, e);
    endtask

    task automatic asyncReset();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_clear", out, 32'd0);
        modelReset();
        @(negedge clk);
        in  = 32'd0;
        rst = 1'b1;
    endtask

    logic [7:0]  lfsrSeq [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    logic [7:0]  ffSum   [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
    logic        ffCarry [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        ffGt    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] firstWord;
    logic [31:0] r;

    initial begin
        rst = 1'b0;
        in  = 32'hFFFF_FFFF;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", out, 32'd0);
        end
        @(negedge clk);
        in  = 32'd0;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'd0, "idle_model");
            checkOutput("lfsr_seq", {24'd0, out[23:16]}, {24'd0, lfsrSeq[i]});
            checkOutput("zero_flag", {31'd0, out[29]}, 32'd1);
            checkOutput("idle_sum", {24'd0, out[7:0]}, 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus($urandom, "pre_async");
        end
        asyncReset();

        applyStimulus(32'd0, "restart");
        checkOutput("lfsr_restart", {24'd0, out[23:16]}, 32'h01);
        applyStimulus(32'hABCD_0035, "b35_drive");
        applyStimulus(32'd0, "b35_result");
        checkOutput("b35_prod", {24'd0, out[15:8]}, 32'h0F);
        checkOutput("b35_ones", {28'd0, out[27:24]}, 32'd4);
        checkOutput("b35_par",  {31'd0, out[28]}, 32'd0);
        checkOutput("b35_zero", {31'd0, out[29]}, 32'd0);
        checkOutput("b35_gt",   {31'd0, out[30]}, 32'd1);
        checkOutput("b35_sum",  {24'd0, out[7:0]}, 32'h35);
        firstWord = out;

        asyncReset();
        applyStimulus(32'd0, "restart2");
        applyStimulus(32'h5A5A_FF35, "b35_hi_drive");
        applyStimulus(32'd0, "b35_hi_result");
        checkOutput("hi_ignored", out, firstWord);

        asyncReset();
        applyStimulus(32'h0000_00FF, "ff_load");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0000_00FF, "ff_model");
            checkOutput("ff_sum", {24'd0, out[7:0]}, {24'd0, ffSum[i]});
            checkOutput("ff_gt", {31'd0, out[30]}, {31'd0, ffGt[i]});
`ifndef D67_OUT_PARITY_EN
            checkOutput("ff_carry", {31'd0, out[31]}, {31'd0, ffCarry[i]});
`endif
        end

        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            applyStimulus(r, "random");
`ifdef D67_OUT_PARITY_EN
            checkOutput("even_parity", {31'd0, ^out}, 32'd0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
